// File: rtl/hc166_shift_reg_pkg.sv
// ----------------------------------------------------------------------------
// hc166_shift_reg_pkg
// Shared definitions for the 74HC166-style shift register model.
//   HC166_WIDTH : register length of the real part (8 bits)
//   mode_t      : the three clocked behaviours of the register
//   decode_mode : maps the active-low enables onto a mode
// ----------------------------------------------------------------------------
package hc166_shift_reg_pkg;

   localparam int HC166_WIDTH = 8;

   typedef enum logic [1:0] {
      MODE_HOLD  = 2'd0,
      MODE_LOAD  = 2'd1,
      MODE_SHIFT = 2'd2
   } mode_t;

   // Clock enable dominates: when it is inhibited the parallel enable is a
   // don't-care, which is how the real part behaves.
   function automatic mode_t decode_mode(input logic ce_n, input logic pe_n);
      if (ce_n) begin
         return MODE_HOLD;
      end else if (!pe_n) begin
         return MODE_LOAD;
      end else begin
         return MODE_SHIFT;
      end
   endfunction

endpackage

// File: rtl/hc166_shift_reg.sv
// ----------------------------------------------------------------------------
// hc166_shift_reg
// Parallel-in / serial-out shift register modelled on the 74HC166. Used in
// the hand-controller system model; two instances daisy-chain (q7 -> ds) to
// form a 16-bit MSB-first chain.
// Ports:
//   cp    : shift/load clock, rising edge
//   mr_n  : master reset, asynchronous, active-low, clears the register
//   ce_n  : clock enable, active-low (high = hold)
//   pe_n  : parallel enable, active-low (low = load d, high = shift)
//   ds    : serial input, enters bit 0 on a shift
//   d     : parallel data, d[WIDTH-1] is the first bit presented on q7
//   q7    : serial output, the top register bit
// ----------------------------------------------------------------------------
module hc166_shift_reg
   import hc166_shift_reg_pkg::*;
#(
   parameter int WIDTH = HC166_WIDTH
) (
   input  logic             cp,
   input  logic             mr_n,
   input  logic             ce_n,
   input  logic             pe_n,
   input  logic             ds,
   input  logic [WIDTH-1:0] d,
   output logic             q7
);

   logic [WIDTH-1:0] q;
   mode_t            mode;

   // Decode the enables into hold/load/shift; only its value at the rising
   // cp edge matters, so glitches between edges have no effect.
   assign mode = decode_mode(ce_n, pe_n);

   // The register itself. Reset wins over everything, including an edge that
   // coincides with mr_n low. Shifting moves data toward the top bit so that
   // the parallel word leaves MSB-first; ds is not masked, so an unknown
   // serial input propagates as X just like the real part would.
   always_ff @(posedge cp or negedge mr_n) begin
      if (!mr_n) begin
         q <= '0;
      end else begin
         case (mode)
            MODE_LOAD:  q <= d;
            MODE_SHIFT: q <= {q[WIDTH-2:0], ds};
            default:    q <= q;
         endcase
      end
   end

   assign q7 = q[WIDTH-1];

endmodule

// File: tb/tb_hc166_shift_reg.sv
// ----------------------------------------------------------------------------
// tb_hc166_shift_reg
// Drives two cascaded hc166_shift_reg instances (dut_a upstream, dut_b
// downstream with ds tied to dut_a.q7) and compares both serial outputs
// against a bit-stream model of the 16-bit chain.
// ----------------------------------------------------------------------------
module tb_hc166_shift_reg;

   logic       cp;
   logic       mr_n;
   logic       ce_n;
   logic       pe_n;
   logic       ds_a;
   logic [7:0] d_a;
   logic [7:0] d_b;
   logic       q7_a;
   logic       q7_b;

   int checks;
   int errors;

   // The chain is modelled as the queue of bits still to come out of the
   // end of the chain: entry 0 is what dut_b presents now, entry 8 is what
   // dut_a presents now. A shift pops the front and appends the new ds.
   logic exp_bits[$];

   hc166_shift_reg #(.WIDTH(8)) dut_a (
      .cp   (cp),
      .mr_n (mr_n),
      .ce_n (ce_n),
      .pe_n (pe_n),
      .ds   (ds_a),
      .d    (d_a),
      .q7   (q7_a)
   );

   hc166_shift_reg #(.WIDTH(8)) dut_b (
      .cp   (cp),
      .mr_n (mr_n),
      .ce_n (ce_n),
      .pe_n (pe_n),
      .ds   (q7_a),
      .d    (d_b),
      .q7   (q7_b)
   );

   // Free-running clock, period 10.
   initial begin
      cp = 1'b0;
      forever #5 cp = ~cp;
   end

   // Safety net so the run can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // A cleared chain is sixteen zeros waiting to come out.
   task automatic model_reset();
      exp_bits.delete();
      for (int i = 0; i < 16; i++) exp_bits.push_back(1'b0);
   endtask

   // Load presents dut_b's word first, then dut_a's, both MSB-first.
   task automatic model_load(input logic [7:0] da, input logic [7:0] db);
      exp_bits.delete();
      for (int i = 7; i >= 0; i--) exp_bits.push_back(db[i]);
      for (int i = 7; i >= 0; i--) exp_bits.push_back(da[i]);
   endtask

   task automatic model_shift(input logic dsv);
      void'(exp_bits.pop_front());
      exp_bits.push_back(dsv);
   endtask

   task automatic check_output(input string tag, input logic observed, input logic expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
      end
   endtask

   // Drive one set of inputs on the falling edge, let one rising edge act on
   // them, update the model and compare both outputs just after the edge.
   // A low mr_n is also checked for its immediate (pre-edge) effect.
   task automatic apply_stimulus(input logic mr, input logic ce, input logic pe,
                                 input logic dsv, input logic [7:0] da,
                                 input logic [7:0] db, input string tag);
      @(negedge cp);
      mr_n = mr;
      ce_n = ce;
      pe_n = pe;
      ds_a = dsv;
      d_a  = da;
      d_b  = db;
      if (!mr) begin
         model_reset();
         #1;
         check_output({tag, "_async_a"}, q7_a, 1'b0);
         check_output({tag, "_async_b"}, q7_b, 1'b0);
      end
      @(posedge cp);
      if (mr && !ce) begin
         if (!pe) model_load(da, db);
         else     model_shift(dsv);
      end
      #1;
      check_output({tag, "_a"}, q7_a, exp_bits[8]);
      check_output({tag, "_b"}, q7_b, exp_bits[0]);
   endtask

   // Reset pulse placed between edges; clock enable is inhibited first so
   // the edge that follows the pulse is a plain hold.
   task automatic pulse_reset(input string tag);
      @(negedge cp);
      ce_n = 1'b1;
      #1;
      mr_n = 1'b0;
      #1;
      model_reset();
      check_output({tag, "_a"}, q7_a, 1'b0);
      check_output({tag, "_b"}, q7_b, 1'b0);
      mr_n = 1'b1;
      @(posedge cp);
      #1;
      check_output({tag, "_hold_a"}, q7_a, exp_bits[8]);
   endtask

   initial begin
      logic [7:0]  pat8;
      logic [15:0] pat16;
      logic        r_mr;
      logic        r_ce;
      logic        r_pe;
      logic        r_ds;

      checks = 0;
      errors = 0;
      mr_n   = 1'b0;
      ce_n   = 1'b0;
      pe_n   = 1'b0;
      ds_a   = 1'b1;
      d_a    = 8'hFF;
      d_b    = 8'hFF;
      model_reset();
      #1;
      check_output("reset_a", q7_a, 1'b0);
      check_output("reset_b", q7_b, 1'b0);

      // Reset held across edges that would otherwise load ones.
      for (int i = 0; i < 3; i++) begin
         apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'($urandom) | 8'h80, 8'hFF, "reset_hold");
      end
      // Release with the clock inhibited: still zero.
      apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'hFF, 8'hFF, "release");

      // Load 0x80 then shift a zero in.
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h80, 8'h00, "load80");
      check_output("load80_const", q7_a, 1'b1);
      apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, "shift80");
      check_output("shift80_const", q7_a, 1'b0);

      // A5 pattern out MSB-first, then constant ones.
      pat8 = 8'hA5;
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, pat8, 8'h00, "a5_load");
      check_output("a5_const0", q7_a, pat8[7]);
      for (int i = 1; i < 12; i++) begin
         apply_stimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, "a5_shift");
         check_output("a5_const", q7_a, (i < 8) ? pat8[7-i] : 1'b1);
      end

      // Clock enable inhibits both shift and load-style behaviour.
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h80, 8'h00, "ce_load");
      for (int i = 0; i < 5; i++) begin
         apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, "ce_hold");
         check_output("ce_hold_const", q7_a, 1'b1);
      end
      apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, "ce_enable");
      check_output("ce_enable_const", q7_a, 1'b0);

      // Cascade: 16'h8001 out of dut_b MSB-first, then zeros.
      pat16 = 16'h8001;
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 8'h80, "casc_load");
      check_output("casc_const0", q7_b, pat16[15]);
      for (int i = 1; i < 20; i++) begin
         apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h01, 8'h80, "casc_shift");
         check_output("casc_const", q7_b, (i < 16) ? pat16[15-i] : 1'b0);
      end

      // Asynchronous reset in the middle of shifting ones.
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'hFF, 8'hFF, "mid_load");
      for (int i = 0; i < 3; i++) begin
         apply_stimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'hFF, 8'hFF, "mid_shift");
      end
      pulse_reset("mid_pulse");
      for (int i = 0; i < 4; i++) begin
         apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'hFF, 8'hFF, "mid_after");
         check_output("mid_after_const", q7_a, 1'b0);
      end

      // Randomized mix of hold, load, shift and occasional reset.
      for (int i = 0; i < 300; i++) begin
         r_mr = ($urandom_range(0, 19) != 0);
         r_ce = ($urandom_range(0, 3) == 0);
         r_pe = ($urandom_range(0, 4) != 0);
         r_ds = 1'($urandom);
         apply_stimulus(r_mr, r_ce, r_pe, r_ds, 8'($urandom), 8'($urandom), "random");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
